// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Keeps the program counter, issues one instruction
// memory read at a time and pushes {pc, instruction} pairs into the downstream
// instruction queue. Redirects from the back end (flush) are honoured even
// while a memory read is in flight: the outstanding response is dropped and
// fetch resumes at the newest redirect target. When the queue is full, a
// returned instruction is parked in a hold register until the queue has room,
// so nothing is lost.
//
// Optional build macro:
//   FETCH_PERF_EN  - adds three 32-bit wrapping performance counters
//                    (perf_fetched, perf_full_stall, perf_flush_drop).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           single-cycle redirect request from the back end
//   redirect_pc     redirect target, valid with flush
//   imem_read       instruction memory read request (held until imem_resp)
//   imem_addr       read address (held until imem_resp)
//   imem_rdata      returned instruction, valid with imem_resp
//   imem_resp       single-cycle read completion
//   iq_full         instruction queue is full
//   iq_enq          enqueue strobe (never asserted while iq_full=1)
//   iq_data         {pc, instr}, pc in the upper half
//   perf_*          performance counters (FETCH_PERF_EN builds only)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h00000060
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               imem_read,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic [WIDTH-1:0]   imem_rdata,
    input  logic               imem_resp,
    input  logic               iq_full,
    output logic               iq_enq,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_full_stall,
    output logic [31:0]        perf_flush_drop,
`endif
    output logic [2*WIDTH-1:0] iq_data
);

    typedef enum logic {
        S_FETCH = 1'b0,  // read request outstanding at pc_q
        S_HOLD  = 1'b1   // returned instruction parked, waiting for queue room
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic                 flush_pending_q, flush_pending_d;
    logic [WIDTH-1:0]     target_q, target_d;
    logic [2*WIDTH-1:0]   hold_q, hold_d;

    logic [WIDTH-1:0]     pc_inc;

    // Modulo 2^WIDTH: the top of the address space wraps to zero.
    assign pc_inc = pc_q + WIDTH'(4);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case/if tree can leave one unassigned and infer a latch.
        state_d         = state_q;
        pc_d            = pc_q;
        flush_pending_d = flush_pending_q;
        target_d        = target_q;
        hold_d          = hold_q;
        imem_read       = 1'b0;
        imem_addr       = pc_q;
        iq_enq          = 1'b0;
        iq_data         = '0;

        // Outputs are forced quiet during the reset cycle itself.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_read = 1'b1;
                    iq_data   = {pc_q, imem_rdata};
                    if (imem_resp) begin
                        if (flush || flush_pending_q) begin
                            // Response belongs to the wrong path: drop it.
                            // A same-cycle flush is newer than any pending one.
                            pc_d            = flush ? redirect_pc : target_q;
                            flush_pending_d = 1'b0;
                        end else if (!iq_full) begin
                            iq_enq = 1'b1;
                            pc_d   = pc_inc;
                        end else begin
                            hold_d  = {pc_q, imem_rdata};
                            state_d = S_HOLD;
                        end
                    end else if (flush) begin
                        // The request cannot be withdrawn, so the redirect is
                        // remembered and applied when the response arrives.
                        // A later flush simply overwrites the target.
                        flush_pending_d = 1'b1;
                        target_d        = redirect_pc;
                    end
                end

                S_HOLD: begin
                    iq_data = hold_q;
                    iq_enq  = ~iq_full & ~flush;
                    if (flush) begin
                        pc_d    = redirect_pc;
                        state_d = S_FETCH;
                    end else if (!iq_full) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end

                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values from
        // before this edge, independent of statement order.
        if (rst) begin
            state_q         <= S_FETCH;
            pc_q            <= RESET_PC;
            flush_pending_q <= 1'b0;
            target_q        <= '0;
            hold_q          <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            flush_pending_q <= flush_pending_d;
            target_q        <= target_d;
            hold_q          <= hold_d;
        end
    end

`ifdef FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (32-bit, wrapping)
    // -------------------------------------------------------------------------
    logic [31:0] perf_fetched_q,    perf_fetched_d;
    logic [31:0] perf_full_stall_q, perf_full_stall_d;
    logic [31:0] perf_flush_drop_q, perf_flush_drop_d;
    logic        drop_event;

    always_comb begin
        // A dropped wrong-path response, or a held entry discarded by flush.
        drop_event = ((state_q == S_FETCH) && imem_resp && (flush || flush_pending_q))
                   || ((state_q == S_HOLD) && flush);

        perf_fetched_d    = perf_fetched_q    + {31'd0, iq_enq};
        perf_full_stall_d = perf_full_stall_q + {31'd0, (state_q == S_HOLD)};
        perf_flush_drop_d = perf_flush_drop_q + {31'd0, drop_event};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q    <= '0;
            perf_full_stall_q <= '0;
            perf_flush_drop_q <= '0;
        end else begin
            perf_fetched_q    <= perf_fetched_d;
            perf_full_stall_q <= perf_full_stall_d;
            perf_flush_drop_q <= perf_flush_drop_d;
        end
    end

    assign perf_fetched    = perf_fetched_q;
    assign perf_full_stall = perf_full_stall_q;
    assign perf_flush_drop = perf_flush_drop_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. Each cycle the bench plays the instruction memory
// (response after a programmable latency, instr = addr ^ A5A5A5A5) and the
// instruction queue (iq_full), and compares the DUT against a transaction-level
// model of the fetch rules: current pc, pending redirect, parked entry.
// Directed scenarios run first, then a randomized phase.
// Build with +define+FETCH_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000060;
    localparam logic [31:0] MAGIC    = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full;
    logic        iq_enq;
    logic [63:0] iq_data;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_full_stall;
    logic [31:0] perf_flush_drop;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .imem_read       (imem_read),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_resp       (imem_resp),
        .iq_full         (iq_full),
        .iq_enq          (iq_enq),
`ifdef FETCH_PERF_EN
        .perf_fetched    (perf_fetched),
        .perf_full_stall (perf_full_stall),
        .perf_flush_drop (perf_flush_drop),
`endif
        .iq_data         (iq_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the fetch stage
    logic [31:0] m_pc;
    logic [31:0] m_target;
    bit          m_pend;
    bit          m_hold;
    logic [63:0] m_held;
    int          m_fetched;
    int          m_stall;
    int          m_drop;

    // Memory model
    int mem_lat;
    int wait_cnt;

    // Per-step samples of the DUT
    logic        s_read;
    logic [31:0] s_addr;
    logic        s_enq;
    logic [63:0] s_data;
    int          obs_enq_cnt;
`ifdef FETCH_PERF_EN
    logic [31:0] s_pf, s_ps, s_pd;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = RESET_PC;
        m_target    = '0;
        m_pend      = 1'b0;
        m_hold      = 1'b0;
        m_held      = '0;
        m_fetched   = 0;
        m_stall     = 0;
        m_drop      = 0;
        wait_cnt    = 0;
        obs_enq_cnt = 0;
    endtask

    // Hold reset for two edges, check the quiet outputs while rst is still
    // high, then release it on a falling edge.
    task automatic do_reset();
        rst         = 1'b1;
        flush       = 1'b0;
        redirect_pc = '0;
        imem_resp   = 1'b0;
        imem_rdata  = '0;
        iq_full     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_read", imem_read, 1'b0);
        check("rst_iq_enq", iq_enq, 1'b0);
        check("rst_iq_data", iq_data, 64'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_full_stall", perf_full_stall, 32'd0);
        check("rst_perf_flush_drop", perf_flush_drop, 32'd0);
`endif
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive queue/flush/memory inputs, check DUT outputs
    // against the model, advance the model.
    task automatic step(input bit full, input bit fl, input logic [31:0] rpc);
        logic        exp_enq;
        logic [63:0] exp_data;
        @(negedge clk);
        s_read = imem_read;
        s_addr = imem_addr;
`ifdef FETCH_PERF_EN
        s_pf = perf_fetched;
        s_ps = perf_full_stall;
        s_pd = perf_flush_drop;
        check("perf_fetched", s_pf, 32'(m_fetched));
        check("perf_full_stall", s_ps, 32'(m_stall));
        check("perf_flush_drop", s_pd, 32'(m_drop));
`endif
        check("imem_read", s_read, !m_hold);
        if (!m_hold) check("imem_addr", s_addr, m_pc);

        iq_full     = full;
        flush       = fl;
        redirect_pc = rpc;
        imem_resp   = s_read && (wait_cnt + 1 >= mem_lat);
        imem_rdata  = imem_resp ? (s_addr ^ MAGIC) : $urandom;
        #1;
        s_enq  = iq_enq;
        s_data = iq_data;
        if (s_enq) obs_enq_cnt++;

        exp_enq  = 1'b0;
        exp_data = '0;
        if (!m_hold) begin
            if (imem_resp) begin
                if (fl || m_pend) begin
                    m_drop++;
                    m_pc   = fl ? rpc : m_target;
                    m_pend = 1'b0;
                end else if (!full) begin
                    exp_enq  = 1'b1;
                    exp_data = {m_pc, m_pc ^ MAGIC};
                    m_pc     = m_pc + 32'd4;
                end else begin
                    m_held = {m_pc, m_pc ^ MAGIC};
                    m_hold = 1'b1;
                end
            end else if (fl) begin
                m_pend   = 1'b1;
                m_target = rpc;
            end
        end else begin
            m_stall++;
            if (fl) begin
                m_drop++;
                m_pc   = rpc;
                m_hold = 1'b0;
            end else if (!full) begin
                exp_enq  = 1'b1;
                exp_data = m_held;
                m_pc     = m_pc + 32'd4;
                m_hold   = 1'b0;
            end
        end

        check("iq_enq", s_enq, exp_enq);
        if (exp_enq) check("iq_data", s_data, exp_data);
        if (exp_enq) m_fetched++;

        if (imem_resp) wait_cnt = 0;
        else if (s_read) wait_cnt++;
    endtask

    initial begin
        mem_lat = 1;
        do_reset();

        // Streaming with 1-cycle memory and an empty queue
        step(0, 0, 0);
        check("tp1_addr0", s_addr, 32'h60);
        check("tp1_data0", s_data, 64'h00000060_A5A5A5C5);
        step(0, 0, 0);
        check("tp1_data1", s_data, 64'h00000064_A5A5A5C1);
        step(0, 0, 0);
        check("tp1_addr2", s_addr, 32'h68);
        step(0, 0, 0);

        // Queue full when the response for 0x70 arrives
        step(1, 0, 0);
        check("tp2_park_enq", s_enq, 1'b0);
        step(1, 0, 0);
        check("tp2_hold_read", s_read, 1'b0);
        step(1, 0, 0);
        step(0, 0, 0);
        check("tp2_release", s_data, {32'h70, 32'h70 ^ MAGIC});
        step(0, 0, 0);
        check("tp2_next_addr", s_addr, 32'h74);
        step(0, 0, 0);
        step(0, 0, 0);

        // 4-cycle memory, flush to 0x200 in the second wait cycle
        mem_lat = 4;
        step(0, 0, 0);
        check("tp3_addr_w1", s_addr, 32'h80);
        step(0, 1, 32'h200);
        step(0, 0, 0);
        check("tp3_addr_w3", s_addr, 32'h80);
        step(0, 0, 0);
        check("tp3_drop", s_enq, 1'b0);
        mem_lat = 1;
        step(0, 0, 0);
        check("tp3_new_addr", s_addr, 32'h200);

        // Flush in the same cycle as the response
        step(0, 1, 32'h300);
        check("tp4_drop", s_enq, 1'b0);
        step(0, 0, 0);
        check("tp4_new_addr", s_addr, 32'h300);

        // Two flushes during one wait: newest target wins
        mem_lat = 4;
        step(0, 0, 0);
        step(0, 1, 32'h400);
        step(0, 1, 32'h500);
        step(0, 0, 0);
        mem_lat = 1;
        step(0, 0, 0);
        check("tp4_double_flush", s_addr, 32'h500);

        // Flush while holding a parked entry
        step(1, 0, 0);
        step(1, 1, 32'h1000);
        check("tp5_discard", s_enq, 1'b0);
        step(0, 0, 0);
        check("tp5_read", s_read, 1'b1);
        check("tp5_addr", s_addr, 32'h1000);

        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFFFFFC);
        step(0, 0, 0);
        check("wrap_data", s_data, 64'hFFFFFFFC_5A5A5A59);
        step(0, 0, 0);
        check("wrap_addr", s_addr, 32'h0);

        // Reset in the middle of an outstanding request
        mem_lat = 3;
        step(0, 0, 0);
        step(0, 0, 0);
        mem_lat = 1;
        do_reset();
        step(0, 0, 0);
        check("midreq_restart", s_addr, RESET_PC);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            if (wait_cnt == 0) mem_lat = int'($urandom_range(1, 4));
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), $urandom);
        end

        // Counter scenario: HOLD for three cycles, then a same-cycle flush drop
        mem_lat = 1;
        do_reset();
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 32'h300);
        step(0, 0, 0);
`ifdef FETCH_PERF_EN
        check("perf_stall_const", s_ps, 32'd3);
        check("perf_drop_const", s_pd, 32'd1);
        check("perf_fetched_const", s_pf, 32'd5);
        check("perf_fetched_obs", s_pf, 32'(obs_enq_cnt - 1));
`endif
        do_reset();
        step(0, 0, 0);
        check("final_addr", s_addr, RESET_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that generates the PC and issues instruction-memory reads.
- Pushes {pc, instruction} pairs into the downstream instruction circular queue (enq/full interface).
- Handles control-flow redirects (flush) from the back end, including one memory request still in flight.
- Stalls on queue back-pressure without losing a returned instruction.

Parameters:
- WIDTH, 32, width of PC and instruction word.
- RESET_PC, 32'h00000060, PC loaded on reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- flush  input  1  redirect request from back end; single-cycle pulse
- redirect_pc  input  WIDTH  target PC, valid when flush=1
- imem_read  output  1  instruction memory read request
- imem_addr  output  WIDTH  read address
- imem_rdata  input  WIDTH  returned instruction, valid when imem_resp=1
- imem_resp  input  1  read completion, single cycle
- iq_full  input  1  instruction queue full
- iq_enq  output  1  enqueue strobe to instruction queue
- iq_data  output  2*WIDTH  {pc[WIDTH-1:0], instr[WIDTH-1:0]}, pc in upper half

Behaviour:
- Reset is synchronous, active-high (rst), on clock clk. On reset:
  - state=FETCH, pc=RESET_PC, flush_pending=0, hold register=0.
  - Outputs: imem_read=0 during the rst cycle, iq_enq=0, iq_data=0.
- Memory protocol: once imem_read=1, imem_read and imem_addr stay stable until the cycle imem_resp=1. The request is never withdrawn early.
- State FETCH:
  - imem_read=1, imem_addr=pc.
  - No imem_resp and flush=1: set flush_pending=1, latch redirect_pc into target. Address stays unchanged. Stay in FETCH.
  - imem_resp=1 and (flush or flush_pending):
    - Drop rdata; iq_enq=0.
    - pc <= flush ? redirect_pc : target. Same-cycle flush wins over an older pending target.
    - Clear flush_pending; stay in FETCH. The new address appears next cycle.
  - imem_resp=1, no flush, iq_full=0:
    - iq_enq=1 in the same cycle (combinational), iq_data={pc, imem_rdata}.
    - pc <= pc+4; stay in FETCH.
  - imem_resp=1, no flush, iq_full=1: latch {pc, imem_rdata} into the hold register; go to HOLD.
- State HOLD:
  - imem_read=0; iq_data=hold register; iq_enq = ~iq_full & ~flush.
  - flush=1: discard held entry, pc <= redirect_pc, go to FETCH.
  - Else if iq_full=0: enqueue, pc <= pc+4, go to FETCH.
  - Else remain in HOLD.
- Invariant: iq_enq is never asserted while iq_full=1. The queue silently drops enqueues when full, so this must hold.
- Flush while flush_pending=1: target updated to the newest redirect_pc.
- PC arithmetic: modulo 2^WIDTH; 32'hFFFFFFFC+4 wraps to 0. redirect_pc is taken as-is; no alignment check.
- Queue contents on flush are cleared externally in the same cycle; this block does not touch the queue's rst.
- Reset mid-request: FETCH restarts at RESET_PC. A late imem_resp for the aborted request is not guarded. The memory model is reset together with this block.
- Throughput: at most one instruction per imem_resp. With 1-cycle memory latency and a non-full queue, one instruction every cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three output ports, each 32 bits, wrapping, reset to 0:
  - perf_fetched: +1 per iq_enq.
  - perf_full_stall: +1 per cycle in HOLD.
  - perf_flush_drop: +1 per dropped response or discarded held entry.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, memory responds in 1 cycle with instr=pc^32'hA5A5A5A5, iq_full=0 → iq_enq each cycle with iq_data {60,A5A5A5C5}, {64,A5A5A5C1}, {68,...}; addresses 0x60,0x64,0x68.
- iq_full=1 when response for pc=0x70 arrives, held 3 cycles → HOLD; imem_read=0 and iq_enq=0 for 3 cycles; on iq_full=0, enqueue {70,instr} once; next imem_addr=0x74.
- 4-cycle memory latency, flush with redirect_pc=0x200 in the 2nd wait cycle → imem_addr stays 0x80 until resp; response dropped (no iq_enq); next imem_addr=0x200.
- flush with redirect_pc=0x300 in the same cycle as imem_resp → no enqueue; next imem_addr=0x300. Repeat with two flushes (0x400 then 0x500) during one wait → fetch resumes at 0x500.
- flush=1 while in HOLD with redirect_pc=0x1000 and iq_full=1 → held entry never enqueued; next cycle imem_read=1, imem_addr=0x1000.
- FETCH_PERF_EN defined, run the HOLD scenario and the 1-cycle flush scenario → perf_full_stall=3, perf_flush_drop=1, perf_fetched equals the observed iq_enq count; rst clears all three to 0.
